// File: rtl/line_burst_adapter.sv
// Adapts single-cycle cache line requests into fixed-length beat bursts toward memory.
// Reads assemble beats into line_rdata; write-backs serialise a latched line one beat at a time.
module line_burst_adapter #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_burst  = 64,
  parameter int unsigned beats    = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [31:0]        line_address,
  input  logic [s_line-1:0]  line_wdata,
  output logic [s_line-1:0]  line_rdata,
  output logic               line_resp,
  output logic               burst_read,
  output logic               burst_write,
  output logic [31:0]        burst_address,
  output logic [s_burst-1:0] burst_wdata,
  input  logic [s_burst-1:0] burst_rdata,
  input  logic               burst_resp
);

  localparam int unsigned KW = (beats > 1) ? $clog2(beats) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [31:0]       addr_q, addr_d;
  logic [s_line-1:0] wbuf_q, wbuf_d;
  logic [s_line-1:0] rdata_q, rdata_d;

  logic [31:0] aligned_addr;
  logic        last_beat;
  logic [KW-1:0] k_inc;

  always_comb begin
    aligned_addr = line_address;
    aligned_addr[s_offset-1:0] = '0;
  end

  assign last_beat = (k_q == KW'(beats - 1));
  assign k_inc     = last_beat ? '0 : k_q + KW'(1);

  // Next-state, beat counter and data capture.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (line_read) begin
          state_d = READ;
          k_d     = '0;
          addr_d  = aligned_addr;
        end else if (line_write) begin
          state_d = WRITE;
          k_d     = '0;
          addr_d  = aligned_addr;
          wbuf_d  = line_wdata;
        end
      end
      READ: begin
        if (burst_resp) begin
          for (int unsigned i = 0; i < beats; i++) begin
            if (k_q == KW'(i)) rdata_d[i*s_burst +: s_burst] = burst_rdata;
          end
          k_d = k_inc;
          if (last_beat) state_d = DONE;
        end
      end
      WRITE: begin
        if (burst_resp) begin
          k_d = k_inc;
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
    end
  end

  // Current write beat selected from the latched line.
  always_comb begin
    burst_wdata = '0;
    for (int unsigned i = 0; i < beats; i++) begin
      if (k_q == KW'(i)) burst_wdata = wbuf_q[i*s_burst +: s_burst];
    end
  end

  assign burst_read    = (state_q == READ);
  assign burst_write   = (state_q == WRITE);
  assign line_resp     = (state_q == DONE);
  assign burst_address = addr_q;
  assign line_rdata    = rdata_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: scoreboard of expected lines/beats checked on DUT output.
module tb_line_burst_adapter;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  line_burst_adapter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_address  (line_address),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_address (burst_address),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int resp_cnt = 0;

  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];

  always @(negedge clk) if (line_resp === 1'b1) resp_cnt++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, line_rdata, 256'd0);
    chk({tag, "_ctrl"}, {253'd0, line_resp, burst_read, burst_write}, 256'd0);
    chk({tag, "_addr"}, {224'd0, burst_address}, 256'd0);
    chk({tag, "_wdata"}, {192'd0, burst_wdata}, 256'd0);
  endtask

  // Waits a bounded number of cycles for line_resp, then checks the popped line.
  task automatic finish_req(input string tag, input logic is_read);
    logic [255:0] exp;
    chk({tag, "_resp_latency"}, {255'd0, line_resp}, 256'd1);
    for (int t = 0; t < 8 && line_resp !== 1'b1; t++) tick();
    if (line_resp !== 1'b1) chk({tag, "_resp_timeout"}, {255'd0, line_resp}, 256'd1);
    chk({tag, "_done_no_burst"}, {254'd0, burst_read, burst_write}, 256'd0);
    if (exp_line_q.size() != 0) begin
      exp = exp_line_q.pop_front();
      chk(is_read ? {tag, "_line"} : {tag, "_rdata_kept"}, line_rdata, exp);
    end else begin
      chk({tag, "_sb_empty"}, 256'(exp_line_q.size()), 256'd1);
    end
    line_read  = 1'b0;
    line_write = 1'b0;
    tick();
    chk({tag, "_idle"}, {253'd0, line_resp, burst_read, burst_write}, 256'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [255:0] ln,
                         input logic [31:0] gaps, input logic also_write);
    line_read    = 1'b1;
    line_write   = also_write;
    line_address = addr;
    line_wdata   = ~ln;
    tick();
    chk({tag, "_burst_read"}, {255'd0, burst_read}, 256'd1);
    chk({tag, "_no_burst_write"}, {255'd0, burst_write}, 256'd0);
    chk({tag, "_addr"}, {224'd0, burst_address}, {224'd0, addr & 32'hFFFF_FFE0});
    exp_line_q.push_back(ln);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < int'(gaps[8*i +: 8]); g++) begin
        burst_resp  = 1'b0;
        burst_rdata = {$urandom, $urandom};
        tick();
        chk({tag, "_gap"}, {253'd0, line_resp, burst_read, burst_write}, 256'd2);
      end
      burst_resp  = 1'b1;
      burst_rdata = ln[64*i +: 64];
      tick();
      if (i < N - 1) chk({tag, "_mid"}, {253'd0, line_resp, burst_read, burst_write}, 256'd2);
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;
    finish_req(tag, 1'b1);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [255:0] w,
                          input logic [255:0] exp_rdata);
    logic [63:0] exp;
    line_write   = 1'b1;
    line_address = addr;
    line_wdata   = w;
    tick();
    line_wdata = ~w;
    chk({tag, "_burst_write"}, {254'd0, burst_read, burst_write}, 256'd1);
    chk({tag, "_addr"}, {224'd0, burst_address}, {224'd0, addr & 32'hFFFF_FFE0});
    for (int i = 0; i < N; i++) exp_beat_q.push_back(w[64*i +: 64]);
    exp_line_q.push_back(exp_rdata);
    for (int i = 0; i < N; i++) begin
      exp = exp_beat_q.pop_front();
      if (i == 2) begin
        burst_resp = 1'b0;
        tick();
        chk({tag, "_stall_beat"}, {192'd0, burst_wdata}, {192'd0, exp});
      end
      burst_resp = 1'b1;
      chk({tag, "_beat"}, {192'd0, burst_wdata}, {192'd0, exp});
      tick();
      if (i < N - 1) chk({tag, "_mid"}, {255'd0, line_resp}, 256'd0);
    end
    burst_resp = 1'b0;
    finish_req(tag, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l1, l2, l3, l4, l5, w1, w2;
    int cnt0;
    l1 = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    l2 = {64'hDEAD_BEEF_0000_0004, 64'h0123_4567_89AB_CDE3, 64'hA5A5_5A5A_F0F0_0F02, 64'h1111_2222_3333_4441};
    l3 = {64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002, 64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000};
    l4 = {64'hF4F4_F4F4_0000_0044, 64'hF3F3_F3F3_0000_0033, 64'hF2F2_F2F2_0000_0022, 64'hF1F1_F1F1_0000_0011};
    l5 = {64'h5555_0000_0000_5503, 64'h5555_0000_0000_5502, 64'h5555_0000_0000_5501, 64'h5555_0000_0000_5500};
    w1 = {64'hAAAA_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hCCCC_0000_0000_0001, 64'hDDDD_0000_0000_0000};
    w2 = {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222, 64'h1111_0000_FFFF_EEEE, 64'hDDDD_CCCC_BBBB_AAAA};

    rst_n = 1'b0; line_read = 1'b0; line_write = 1'b0; line_address = '0;
    line_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    do_read("rd_basic", 32'h0000_1234, l1, 32'h0, 1'b0);
    do_write("wr_basic", 32'h8000_0040, w1, l1);
    do_read("rd_gaps", 32'h0000_4A7C, l2, 32'h05_01_03_00, 1'b0);
    do_read("rd_prio", 32'h0000_2000, l3, 32'h0, 1'b1);

    // Read aborted by reset after two beats.
    cnt0 = resp_cnt;
    line_read = 1'b1;
    line_address = 32'h0000_3010;
    tick();
    for (int i = 0; i < 2; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = 64'hBAD0_0000_0000_0000 | 64'(i);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk_all_zero("abort_rst1");
    line_read = 1'b0;
    burst_resp = 1'b0;
    tick();
    chk_all_zero("abort_rst2");
    rst_n = 1'b1;
    tick();
    chk("abort_no_resp", 256'(resp_cnt - cnt0), 256'd0);
    do_read("rd_after_rst", 32'h0000_3010, l4, 32'h00_02_00_01, 1'b0);

    cnt0 = resp_cnt;
    do_read("b2b_rd", 32'h0000_5000, l5, 32'h0, 1'b0);
    do_write("b2b_wr", 32'h0000_6000, w2, l5);
    tick();
    chk("b2b_resp_count", 256'(resp_cnt - cnt0), 256'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_burst_adapter.md
LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

Interface
REQ-001 SHALL have parameters: s_offset, default 5, line byte-offset bits; s_line, default 256, line width in bits; s_burst, default 64, beat width in bits; beats = s_line/s_burst, default 4.
REQ-002 SHALL have ports, in this order (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- line_read  in  1  line read request from the cache, held until line_resp.
- line_write  in  1  line write-back request, held until line_resp.
- line_address  in  32  line request address.
- line_wdata  in  s_line  write-back line data.
- line_rdata  out  s_line  assembled read line.
- line_resp  out  1  one-cycle completion pulse.
- burst_read  out  1  burst read request to memory.
- burst_write  out  1  burst write request to memory.
- burst_address  out  32  line-aligned burst address.
- burst_wdata  out  s_burst  current write beat.
- burst_rdata  in  s_burst  current read beat.
- burst_resp  in  1  beat accepted or valid, once per beat.

Function
REQ-003 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-004 In IDLE with line_read=1, SHALL latch line_address with bits [s_offset-1:0] forced to 0, clear beat counter, and enter READ.
REQ-005 In IDLE with line_write=1 and line_read=0, SHALL latch the aligned address and line_wdata, clear beat counter, and enter WRITE.
REQ-006 SHALL give line_read priority when line_read and line_write are both 1 in IDLE.
REQ-007 burst_read SHALL be 1 exactly while in READ; burst_write SHALL be 1 exactly while in WRITE; both are registered-state decodes with no combinational path from line_* inputs.
REQ-008 burst_address SHALL equal the latched aligned address from the cycle after acceptance and hold until the next acceptance.
REQ-009 In READ, each cycle with burst_resp=1 SHALL store burst_rdata into line_rdata bits [s_burst*k+s_burst-1 : s_burst*k], where k is the beat counter, then increment k.
REQ-010 In WRITE, burst_wdata SHALL equal latched-line bits [s_burst*k+s_burst-1 : s_burst*k]; each cycle with burst_resp=1 SHALL increment k.
REQ-011 On burst_resp with k=beats-1, SHALL enter DONE on the same edge; k SHALL wrap to 0.
REQ-012 burst_resp=0 cycles SHALL stall without changing k or data; there is no latency limit.
REQ-013 line_resp SHALL be 1 exactly while in DONE (one cycle). DONE SHALL always go to IDLE on the next edge.
REQ-014 line_read and line_write SHALL be ignored in READ, WRITE and DONE; the requester drops its request the cycle after line_resp.
REQ-015 line_rdata SHALL be complete and stable in DONE and SHALL hold until overwritten by a later read's beats; a write SHALL NOT alter line_rdata.
REQ-016 burst_resp SHALL be ignored in IDLE and DONE.
REQ-017 Minimum request-to-line_resp latency SHALL be beats+1 cycles: 1 accept cycle plus one cycle per beat with burst_resp held at 1.

Reset
REQ-018 With rst_n=0 at a clock edge, SHALL enter IDLE and clear k, the address, the write buffer and line_rdata to 0. line_resp, burst_read and burst_write SHALL be 0 from that edge.
REQ-019 Reset asserted mid-burst SHALL abandon the transfer with no line_resp; the next request after reset SHALL start from beat 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Read 0x0000_1234, burst_resp every cycle with beats 0x11..,0x22..,0x33..,0x44.. -> burst_address=0x0000_1220; line_rdata={0x44..,0x33..,0x22..,0x11..}; line_resp at cycle 5.
- Write 0x8000_0040 with line_wdata=W, burst_resp every cycle -> burst_wdata = W[63:0], W[127:64], W[191:128], W[255:192] in order; one line_resp; line_rdata unchanged.
- Read with burst_resp gaps of 0, 3, 1 and 5 idle cycles between beats -> data correct; k holds during gaps; line_resp only after the 4th beat.
- line_read and line_write both 1 in IDLE -> READ taken; burst_write never asserted.
- rst_n=0 after beat 2 of a read, then a new read -> no line_resp for the aborted read; all outputs 0 during reset; new read completes with 4 fresh beats.
- Back-to-back read then write, each request dropped after line_resp -> exactly two line_resp pulses; no spurious burst request in DONE.
